// File: rtl/mem_port_arbiter_if.sv
// Bundle shared by the pipeline ports, the memory-port arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the pipeline-plus-memory side.
interface mem_port_arbiter_if;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned MAW = 30;

    logic           if_req;
    logic [AW-1:0]  if_addr;
    logic           if_valid;
    logic [DW-1:0]  if_rdata;
    logic           if_stall;
    logic           if_err;

    logic           d_req;
    logic           d_we;
    logic [AW-1:0]  d_addr;
    logic [DW-1:0]  d_wdata;
    logic           d_valid;
    logic [DW-1:0]  d_rdata;
    logic           d_err;

    logic           mem_en;
    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_valid, if_rdata, if_stall, if_err,
        output d_valid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_valid, if_rdata, if_stall, if_err,
        input  d_valid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and data stages: arbitrates,
// bounds/alignment-checks, issues one word access at a time and returns registered results.
module mem_port_arbiter #(
    parameter int unsigned LAT        = 1,
    parameter logic [31:0] MEM_LO     = 32'h0000_0000,
    parameter logic [31:0] MEM_HI     = 32'h0000_FFFC,
    parameter int unsigned MAX_STREAK = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CW         = 4;
    localparam logic [CW-1:0] LAT_C    = CW'(LAT);
    localparam logic [CW-1:0] STREAK_C = CW'(MAX_STREAK);
    localparam logic [31:0]   SPAN     = MEM_HI - MEM_LO;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

    state_t        state;
    logic [CW-1:0] streak;
    logic [CW-1:0] lat_cnt;
    logic          owner_d;
    logic          we_q;

    logic          grant_d_c;
    logic          grant_f_c;
    logic [31:0]   sel_addr_c;
    logic [31:0]   offset_c;
    logic          bad_c;

    // Data wins a tie unless fetch has already waited through MAX_STREAK data grants.
    // Offset compare covers both bounds in one unsigned test (below MEM_LO wraps high).
    always_comb begin
        grant_d_c  = bus.d_req & (~bus.if_req | (streak != STREAK_C));
        grant_f_c  = bus.if_req & ~grant_d_c;
        sel_addr_c = grant_d_c ? bus.d_addr : bus.if_addr;
        offset_c   = sel_addr_c - MEM_LO;
        bad_c      = (offset_c > SPAN) | (sel_addr_c[1:0] != 2'b00);
    end

    assign bus.if_stall = bus.if_req & ~bus.if_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            streak        <= '0;
            lat_cnt       <= '0;
            owner_d       <= 1'b0;
            we_q          <= 1'b0;
            bus.if_valid  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_err    <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_err     <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.if_err   <= 1'b0;
            bus.d_valid  <= 1'b0;
            bus.d_err    <= 1'b0;

            unique case (state)
                // RESP and ERR pulse their outputs on entry, so here they arbitrate like IDLE.
                IDLE, RESP, ERR: begin
                    if (!bus.if_req || grant_f_c) begin
                        streak <= '0;
                    end else if (grant_d_c && (streak != STREAK_C)) begin
                        streak <= streak + CW'(1);
                    end

                    if (grant_d_c || grant_f_c) begin
                        owner_d <= grant_d_c;
                        we_q    <= grant_d_c & bus.d_we;
                        if (bad_c) begin
                            state <= ERR;
                            if (grant_d_c) begin
                                bus.d_valid <= 1'b1;
                                bus.d_err   <= 1'b1;
                                bus.d_rdata <= '0;
                            end else begin
                                bus.if_valid <= 1'b1;
                                bus.if_err   <= 1'b1;
                                bus.if_rdata <= '0;
                            end
                        end else begin
                            state         <= ISSUE;
                            bus.mem_en    <= 1'b1;
                            bus.mem_we    <= grant_d_c & bus.d_we;
                            bus.mem_addr  <= sel_addr_c[31:2];
                            bus.mem_wdata <= grant_d_c ? bus.d_wdata : 32'h0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                ISSUE: begin
                    lat_cnt <= LAT_C;
                    state   <= WAIT;
                end

                WAIT: begin
                    if (lat_cnt == CW'(1)) begin
                        lat_cnt <= '0;
                        state   <= RESP;
                        if (owner_d) begin
                            bus.d_valid <= 1'b1;
                            bus.d_rdata <= we_q ? 32'h0 : bus.mem_rdata;
                        end else begin
                            bus.if_valid <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (LAT=1 and LAT=2), each with its own behavioural memory.
module tb_mem_port_arbiter;
    localparam logic [31:0] JUNK = 32'hBAD0_0BAD;

    logic        clk = 1'b0;
    logic        rst1;
    logic        rst2;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic        bd1_we;
    logic        bd2_we;
    logic [13:0] bd_a;
    logic [31:0] bd_d;
    logic [31:0] mem1 [0:16383];
    logic [31:0] mem2 [0:16383];
    logic [31:0] rd2_a;

    mem_port_arbiter_if b1();
    mem_port_arbiter_if b2();

    mem_port_arbiter #(.LAT(1), .MEM_LO(32'h0), .MEM_HI(32'h0000_FFFC), .MAX_STREAK(4))
        u_lat1 (.clk(clk), .reset(rst1), .bus(b1));
    mem_port_arbiter #(.LAT(2), .MEM_LO(32'h0), .MEM_HI(32'h0000_FFFC), .MAX_STREAK(4))
        u_lat2 (.clk(clk), .reset(rst2), .bus(b2));

    always #5 clk = ~clk;

    // Memory models return JUNK except in exactly the cycle a read becomes valid.
    always @(posedge clk) begin
        if (bd1_we) mem1[bd_a] <= bd_d;
        if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[13:0]] <= b1.mem_wdata;
        b1.mem_rdata <= b1.mem_en ? mem1[b1.mem_addr[13:0]] : JUNK;
    end

    always @(posedge clk) begin
        if (bd2_we) mem2[bd_a] <= bd_d;
        if (b2.mem_en && b2.mem_we) mem2[b2.mem_addr[13:0]] <= b2.mem_wdata;
        rd2_a        <= b2.mem_en ? mem2[b2.mem_addr[13:0]] : JUNK;
        b2.mem_rdata <= rd2_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic which, input logic [13:0] a, input logic [31:0] d);
        bd_a = a;
        bd_d = d;
        if (which) bd2_we = 1'b1; else bd1_we = 1'b1;
        tick();
        bd1_we = 1'b0;
        bd2_we = 1'b0;
    endtask

    logic [9:0]  got_seq;
    logic [9:0]  exp_seq;
    int unsigned n_got;
    int unsigned n_pulse;

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        bd1_we = 1'b0; bd2_we = 1'b0; bd_a = '0; bd_d = '0;
        got_seq = '0; n_got = 0; n_pulse = 0;
        b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
        b1.d_addr = '0;   b1.d_wdata = '0;
        b2.if_req = 1'b0; b2.if_addr = '0; b2.d_req = 1'b0; b2.d_we = 1'b0;
        b2.d_addr = '0;   b2.d_wdata = '0;

        preload(1'b0, 14'h0010, 32'hDEAD_BEEF);
        preload(1'b0, 14'h0020, 32'h0F0F_1234);
        preload(1'b0, 14'h0080, 32'hCAFE_F00D);
        preload(1'b0, 14'h3FFF, 32'h600D_F00D);
        preload(1'b1, 14'h0040, 32'hFFFF_FFFF);
        preload(1'b1, 14'h0011, 32'h1111_2222);

        // Reset state
        check("rst_if_valid", 32'(b1.if_valid), 32'h0);
        check("rst_d_valid",  32'(b1.d_valid),  32'h0);
        check("rst_mem_en",   32'(b1.mem_en),   32'h0);
        check("rst_mem_addr", 32'(b1.mem_addr), 32'h0);
        check("rst_d_rdata2", b2.d_rdata,       32'h0);
        rst1 = 1'b0; rst2 = 1'b0;
        tick();

        // Fetch only, LAT=1
        b1.if_req = 1'b1; b1.if_addr = 32'h40;
        #1 check("f_stall_c0", 32'(b1.if_stall), 32'h1);
        tick();
        check("f_mem_en_c1",   32'(b1.mem_en),   32'h1);
        check("f_mem_addr_c1", 32'(b1.mem_addr), 32'h10);
        check("f_mem_we_c1",   32'(b1.mem_we),   32'h0);
        check("f_stall_c1",    32'(b1.if_stall), 32'h1);
        tick();
        check("f_mem_en_c2",   32'(b1.mem_en),   32'h0);
        check("f_valid_c2",    32'(b1.if_valid), 32'h0);
        check("f_stall_c2",    32'(b1.if_stall), 32'h1);
        tick();
        check("f_valid_c3",    32'(b1.if_valid), 32'h1);
        check("f_rdata_c3",    b1.if_rdata,      32'hDEAD_BEEF);
        check("f_err_c3",      32'(b1.if_err),   32'h0);
        check("f_stall_c3",    32'(b1.if_stall), 32'h0);
        b1.if_req = 1'b0;
        tick();
        check("f_valid_c4",    32'(b1.if_valid), 32'h0);
        check("f_mem_en_c4",   32'(b1.mem_en),   32'h0);

        // Store then load, LAT=2; the load is re-requested in the store's valid cycle
        b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 32'h100; b2.d_wdata = 32'h1234_5678;
        tick();
        check("st_mem_en",    32'(b2.mem_en),   32'h1);
        check("st_mem_we",    32'(b2.mem_we),   32'h1);
        check("st_mem_addr",  32'(b2.mem_addr), 32'h40);
        check("st_mem_wdata", b2.mem_wdata,     32'h1234_5678);
        tick();
        check("st_mem_we_c2", 32'(b2.mem_we),   32'h0);
        tick();
        check("st_valid_c3",  32'(b2.d_valid),  32'h0);
        tick();
        check("st_valid_c4",  32'(b2.d_valid),  32'h1);
        check("st_rdata_c4",  b2.d_rdata,       32'h0);
        check("st_err_c4",    32'(b2.d_err),    32'h0);
        b2.d_we = 1'b0;
        tick();
        check("ld_mem_en",    32'(b2.mem_en),   32'h1);
        check("ld_mem_we",    32'(b2.mem_we),   32'h0);
        tick();
        tick();
        check("ld_valid_c7",  32'(b2.d_valid),  32'h0);
        tick();
        check("ld_valid_c8",  32'(b2.d_valid),  32'h1);
        check("ld_rdata_c8",  b2.d_rdata,       32'h1234_5678);
        b2.d_req = 1'b0;
        tick();

        // Simultaneous requests held continuously, LAT=1
        b1.if_addr = 32'h80; b1.d_addr = 32'h200; b1.d_we = 1'b0;
        b1.if_req = 1'b1; b1.d_req = 1'b1;
        for (int c = 0; c < 60 && n_got < 10; c++) begin
            tick();
            if (b1.d_valid === 1'b1 && n_got < 10) begin
                check("sim_d_rdata", b1.d_rdata, 32'hCAFE_F00D);
                got_seq[n_got] = 1'b1;
                n_got++;
            end
            if (b1.if_valid === 1'b1 && n_got < 10) begin
                check("sim_if_rdata", b1.if_rdata, 32'h0F0F_1234);
                got_seq[n_got] = 1'b0;
                n_got++;
            end
        end
        b1.if_req = 1'b0; b1.d_req = 1'b0;
        check("sim_count", 32'(n_got), 32'd10);
        exp_seq = 10'b01_1110_1111;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("sim_grant%0d", i), 32'(got_seq[i]), 32'(exp_seq[i]));
        end
        for (int i = 0; i < 6; i++) tick();

        // Errors: misaligned and out-of-bounds data, out-of-bounds fetch
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h102;
        tick();
        check("mis_d_valid", 32'(b1.d_valid), 32'h1);
        check("mis_d_err",   32'(b1.d_err),   32'h1);
        check("mis_d_rdata", b1.d_rdata,      32'h0);
        check("mis_mem_en",  32'(b1.mem_en),  32'h0);
        b1.d_req = 1'b0;
        tick();
        check("mis_d_valid_c2", 32'(b1.d_valid), 32'h0);
        check("mis_mem_en_c2",  32'(b1.mem_en),  32'h0);
        b1.d_req = 1'b1; b1.d_addr = 32'h2_0000;
        tick();
        check("oob_d_valid", 32'(b1.d_valid), 32'h1);
        check("oob_d_err",   32'(b1.d_err),   32'h1);
        check("oob_mem_en",  32'(b1.mem_en),  32'h0);
        b1.d_req = 1'b0;
        tick();
        check("oob_mem_en_c2", 32'(b1.mem_en), 32'h0);
        b1.if_req = 1'b1; b1.if_addr = 32'h1_0000;
        tick();
        check("oob_if_valid", 32'(b1.if_valid), 32'h1);
        check("oob_if_err",   32'(b1.if_err),   32'h1);
        check("oob_if_rdata", b1.if_rdata,      32'h0);
        check("oob_if_mem_en", 32'(b1.mem_en),  32'h0);
        b1.if_req = 1'b0;
        tick();

        // Highest legal address is accepted
        b1.d_req = 1'b1; b1.d_addr = 32'h0000_FFFC;
        tick();
        check("hi_mem_en",   32'(b1.mem_en),   32'h1);
        check("hi_mem_addr", 32'(b1.mem_addr), 32'h3FFF);
        tick();
        tick();
        check("hi_d_valid",  32'(b1.d_valid),  32'h1);
        check("hi_d_err",    32'(b1.d_err),    32'h0);
        check("hi_d_rdata",  b1.d_rdata,       32'h600D_F00D);
        b1.d_req = 1'b0;
        tick();

        // Reset during WAIT abandons the access, then a fresh fetch completes
        b2.if_req = 1'b1; b2.if_addr = 32'h44;
        tick();
        check("rw_mem_en", 32'(b2.mem_en), 32'h1);
        tick();
        rst2 = 1'b1; b2.if_req = 1'b0;
        tick();
        check("rw_if_valid", 32'(b2.if_valid), 32'h0);
        check("rw_mem_en0",  32'(b2.mem_en),   32'h0);
        check("rw_d_rdata",  b2.d_rdata,       32'h0);
        check("rw_mem_addr", 32'(b2.mem_addr), 32'h0);
        rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b2.if_valid !== 1'b0) n_pulse++;
        end
        check("rw_no_pulse", 32'(n_pulse), 32'h0);
        b2.if_req = 1'b1; b2.if_addr = 32'h44;
        for (int i = 0; i < 4; i++) tick();
        check("rw_new_valid", 32'(b2.if_valid), 32'h1);
        check("rw_new_rdata", b2.if_rdata,      32'h1111_2222);
        b2.if_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the single physical port of the unified instruction/data memory between the fetch stage and the memory stage of the pipeline. It serialises accesses and issues one word access at a time to a memory with fixed synchronous read latency. It returns registered results with a one-cycle valid pulse. Bounds and alignment are checked before issue, and stall signals are driven back to the pipeline.

## Interface
- LAT, 1: memory read latency in cycles from the issue cycle to valid mem_rdata; legal range 1..15.
- MEM_LO, 32'h0000_0000: lowest legal byte address, inclusive.
- MEM_HI, 32'h0000_FFFC: highest legal byte address, inclusive.
- MAX_STREAK, 4: maximum number of consecutive data grants while fetch is waiting; legal range 1..15.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_valid.
- if_addr  in  32  fetch byte address (PC).
- if_valid  out  1  one-cycle pulse: if_rdata valid, fetch access complete.
- if_rdata  out  32  fetched instruction word.
- if_stall  out  1  if_req & ~if_valid.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_valid  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load data; 0 for stores and for errored accesses.
- d_err  out  1  pulses with d_valid when the data address is out of bounds or misaligned.
- if_err  out  1  pulses with if_valid when the fetch address is out of bounds or misaligned.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_we  out  1  write strobe; only asserted together with mem_en.
- mem_addr  out  30  word address, equal to the byte address >> 2.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid LAT cycles after mem_en.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- **IDLE**
  - Samples the requests. If neither is pending, stay in IDLE.
  - If only one request is pending, grant it.
  - If both are pending, grant data, unless streak == MAX_STREAK, in which case grant fetch.
  - The granted owner, address, we and wdata are latched.
  - Go to ERR if the latched address is outside [MEM_LO, MEM_HI] or addr[1:0] != 0; otherwise go to ISSUE.
- **Streak counter (4 bits)**
  - Increments on a data grant made while if_req is high.
  - Clears on any fetch grant, and on any IDLE cycle with if_req low.
  - Saturates at MAX_STREAK.
- **ISSUE**
  - Drives mem_en=1, mem_addr = addr[31:2], mem_we = owner_is_data & we, mem_wdata = latched wdata.
  - Loads the latency counter with LAT and goes to WAIT.
- **WAIT**
  - Decrements the counter each cycle.
  - On the cycle the counter reaches 1, captures mem_rdata into the owner's rdata register (0 for stores) and goes to RESP.
- **RESP**
  - Pulses the owner's valid.
  - Simultaneously behaves as IDLE: it samples requests and may grant the next access in the same cycle.
- **ERR**
  - Pulses the owner's valid and err, with rdata = 0. No memory access occurs.
  - Simultaneously behaves as IDLE.
- A requester that drops req before its valid pulse still receives the pulse. The access is not cancelled.
- A requester that keeps req high through its valid cycle is treated as issuing a new request.
- mem_en, mem_we and all valid/err outputs are 0 outside the states listed above.

## Timing
- Request sampled at cycle N → mem_en at N+1 → mem_rdata captured at N+1+LAT → valid pulse at N+2+LAT.
- Throughput is one access per LAT+2 cycles.
- An errored access produces valid+err at N+1.
- A store is committed to memory at N+1. Its d_valid pulses at N+2+LAT.
- Reset values: state IDLE; streak 0; latency counter 0; all outputs 0.
- Reset asserted mid-access abandons it: no valid pulse is produced. A store already issued remains written.
- Stall outputs are combinational from req and valid; every other output is registered.

## Test plan
- **Fetch only, LAT=1:** if_req with if_addr=0x40 at cycle 0, memory word 0x10 = 0xDEADBEEF → mem_en and mem_addr=0x10 at cycle 1; if_valid=1 and if_rdata=0xDEADBEEF at cycle 3; if_stall=1 in cycles 0–2.
- **Store then load, LAT=2:** store 0x12345678 to 0x100, then load 0x100 → mem_we=1 in the issue cycle only; d_valid at +4 with d_rdata=0; the load returns 0x12345678.
- **Simultaneous requests:** if_req and d_req both held continuously, MAX_STREAK=4 → grant order D, D, D, D, F, D, D, D, D, F, …
- **Errors:** d_addr=0x102 (misaligned) or 0x20000 (out of bounds) → d_valid=1, d_err=1 and d_rdata=0 one cycle later; mem_en never asserts.
- **Reset mid-access:** reset in the WAIT cycle → no valid pulse; all outputs 0; the next request completes normally.
